// File: rtl/univ_gate_bist.sv
// rtl/univ_gate_bist.sv - N-input switch-level NAND/NOR gate with exhaustive self-test
module univ_gate_bist #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         mode,
    input  logic [N-1:0] ext_in,
    input  logic         start,
    input  logic         fault_en,
    output logic         gate_out,
    output logic         busy,
    output logic         done,
    output logic         pass,
    output logic [N:0]   err_count,
    output logic [N-1:0] first_fail
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_APPLY = 2'd1,
        S_CHECK = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t       state;
    state_t       state_nx;
    logic [N-1:0] vec;
    logic         mode_q;
    logic [N-1:0] sel_vec;
    logic [N-1:0] cin;
    logic         mode_sel;
    logic         core_y;
    logic         ref_y;
    logic         mismatch;

    supply0 gnd;
    supply1 vdd;

    wire         nand_y;
    wire         nor_y;
    wire [N-2:0] nn;
    wire [N-2:0] pn;

    // Transistor-level cores; every input vector closes exactly one of the
    // pull-up / pull-down networks, so neither output ever floats.
    for (genvar k = 0; k < N; k++) begin : g_core
        pmos p_nand (nand_y, vdd, cin[k]);
        nmos n_nor  (nor_y,  gnd, cin[k]);
        if (k == 0) begin : g_first
            nmos n_nand (nn[0], gnd, cin[0]);
            pmos p_nor  (pn[0], vdd, cin[0]);
        end else if (k == N - 1) begin : g_last
            nmos n_nand (nand_y, nn[k-1], cin[k]);
            pmos p_nor  (nor_y,  pn[k-1], cin[k]);
        end else begin : g_mid
            nmos n_nand (nn[k], nn[k-1], cin[k]);
            pmos p_nor  (pn[k], pn[k-1], cin[k]);
        end
    end

    assign busy     = (state == S_APPLY) || (state == S_CHECK);
    assign done     = (state == S_DONE);
    assign sel_vec  = busy ? vec : ext_in;
    assign mode_sel = busy ? mode_q : mode;

    // Fault forces bit 0 low on the core only; the reference sees vec untouched.
    always_comb begin
        cin    = sel_vec;
        cin[0] = sel_vec[0] & ~fault_en;
    end

    assign core_y   = mode_sel ? nor_y : nand_y;
    assign ref_y    = mode_q ? ~(|vec) : ~(&vec);
    assign mismatch = (state == S_CHECK) && (core_y != ref_y);

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = S_APPLY;
            S_APPLY: state_nx = S_CHECK;
            S_CHECK: state_nx = (vec == {N{1'b1}}) ? S_DONE : S_APPLY;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            vec        <= '0;
            mode_q     <= 1'b0;
            gate_out   <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            first_fail <= '0;
        end else begin
            state <= state_nx;
            case (state)
                S_IDLE: begin
                    gate_out <= core_y;
                    if (start) begin
                        err_count  <= '0;
                        first_fail <= '0;
                        pass       <= 1'b0;
                        vec        <= '0;
                        mode_q     <= mode;
                    end
                end
                S_CHECK: begin
                    if (mismatch) begin
                        err_count <= err_count + (N+1)'(1);
                        if (err_count == '0) first_fail <= vec;
                    end
                    // pass is resolved here so it is already valid in the DONE cycle
                    if (vec == {N{1'b1}}) pass <= !mismatch && (err_count == '0);
                    else                  vec  <= vec + N'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_univ_gate_bist.sv
// tb/tb_univ_gate_bist.sv - self-checking bench for univ_gate_bist
module tb_univ_gate_bist;
    localparam int N     = 4;
    localparam int TLEN  = 2 * (1 << N) + 1;
    localparam logic [N-1:0] ONES = {N{1'b1}};

    logic         clk = 1'b0;
    logic         rst_n;
    logic         mode;
    logic [N-1:0] ext_in;
    logic         start;
    logic         fault_en;
    logic         gate_out;
    logic         busy;
    logic         done;
    logic         pass;
    logic [N:0]   err_count;
    logic [N-1:0] first_fail;

    int checks = 0;
    int errors = 0;

    univ_gate_bist #(.N(N)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .ext_in(ext_in), .start(start),
        .fault_en(fault_en), .gate_out(gate_out), .busy(busy), .done(done),
        .pass(pass), .err_count(err_count), .first_fail(first_fail)
    );

    always #5 clk = ~clk;

    function automatic logic gate_fn(input logic [N-1:0] v, input logic m);
        if (m) return (v == '0);
        return (v != ONES);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: cnt = cycle number inside a test (1..TLEN), 0 when idle.
    int           cnt = 0;
    logic         ge = 0, pe = 0, mq = 0;
    int           ee = 0, te = 0;
    logic [N-1:0] fe = '0, tf = '0;

    always @(posedge clk) begin
        if (!rst_n) begin
            cnt = 0; ge = 0; pe = 0; ee = 0; fe = '0;
        end else if (cnt == 0) begin
            ge = gate_fn(fault_en ? (ext_in & ~N'(1)) : ext_in, mode);
            if (start) begin
                cnt = 1; ee = 0; fe = '0; pe = 0; mq = mode;
                te = 0; tf = '0;
                for (int v = 0; v < (1 << N); v++) begin
                    logic [N-1:0] vv, cv;
                    vv = N'(v);
                    cv = fault_en ? (vv & ~N'(1)) : vv;
                    if (gate_fn(cv, mq) != gate_fn(vv, mq)) begin
                        if (te == 0) tf = vv;
                        te++;
                    end
                end
            end
        end else if (cnt == TLEN) begin
            cnt = 0;
        end else begin
            cnt++;
            if (cnt == TLEN) begin
                ee = te; fe = tf; pe = (te == 0);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n !== 1'bx) begin
            check("busy", int'(busy), int'(cnt >= 1 && cnt < TLEN));
            check("done", int'(done), int'(cnt == TLEN));
            check("gate_out", int'(gate_out), int'(ge));
            if (cnt == 0 || cnt == TLEN) begin
                check("err_count", int'(err_count), ee);
                check("first_fail", int'(first_fail), int'(fe));
                check("pass", int'(pass), int'(pe));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start, then count cycles until done; returns cycle of done (0 on timeout).
    task automatic run_test(input logic m, input logic f, output int dcyc);
        mode = m; fault_en = f; start = 1'b1;
        tick();
        start = 1'b0;
        dcyc = 0;
        for (int c = 1; c <= TLEN + 5; c++) begin
            if (done) begin
                dcyc = c;
                break;
            end
            tick();
        end
        if (dcyc == 0) begin
            errors++;
            checks++;
            $display("FAIL done_timeout: got no done expected done at cycle %0d", TLEN);
        end
    endtask

    int dc;
    int seen_done;

    initial begin
        rst_n = 1'b0; mode = 0; ext_in = '0; start = 0; fault_en = 0;
        repeat (3) tick();
        check("rst_gate_out", int'(gate_out), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_err", int'(err_count), 0);
        rst_n = 1'b1;

        mode = 0; ext_in = 4'b1111; tick(); check("nand_1111", int'(gate_out), 0);
        ext_in = 4'b1011; tick(); check("nand_1011", int'(gate_out), 1);
        mode = 1; ext_in = 4'b0000; tick(); check("nor_0000", int'(gate_out), 1);
        ext_in = 4'b0100; tick(); check("nor_0100", int'(gate_out), 0);

        run_test(1'b0, 1'b0, dc);
        check("nand_clean_done_cyc", dc, 33);
        check("nand_clean_pass", int'(pass), 1);
        check("nand_clean_err", int'(err_count), 0);
        check("nand_clean_ff", int'(first_fail), 0);
        tick();

        run_test(1'b1, 1'b0, dc);
        check("nor_clean_done_cyc", dc, 33);
        check("nor_clean_pass", int'(pass), 1);
        tick();

        run_test(1'b0, 1'b1, dc);
        check("nand_fault_err", int'(err_count), 1);
        check("nand_fault_ff", int'(first_fail), 4'b1111);
        check("nand_fault_pass", int'(pass), 0);
        tick();

        run_test(1'b1, 1'b1, dc);
        check("nor_fault_err", int'(err_count), 1);
        check("nor_fault_ff", int'(first_fail), 4'b0001);
        check("nor_fault_pass", int'(pass), 0);
        tick();

        // start/mode wiggled mid-test must not restart or change the mode used
        mode = 0; fault_en = 1; start = 1; tick(); start = 0;
        dc = 0;
        for (int c = 1; c <= TLEN + 5; c++) begin
            if (c == 5) begin mode = 1; start = 1; end
            if (c == 8) start = 0;
            if (done) begin dc = c; break; end
            tick();
        end
        check("abort_ign_done_cyc", dc, 33);
        check("abort_ign_err", int'(err_count), 1);
        check("abort_ign_ff", int'(first_fail), 4'b1111);
        tick();

        // reset at cycle 10 of a test
        mode = 0; fault_en = 0; start = 1; tick(); start = 0;
        repeat (9) tick();
        rst_n = 0;
        seen_done = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (done) seen_done = 1;
        end
        rst_n = 1;
        check("rst_mid_busy", int'(busy), 0);
        check("rst_mid_gate", int'(gate_out), 0);
        for (int c = 0; c < 40; c++) begin
            tick();
            if (done) seen_done = 1;
        end
        check("rst_mid_no_done", seen_done, 0);

        run_test(1'b0, 1'b0, dc);
        check("fresh_done_cyc", dc, 33);
        check("fresh_pass", int'(pass), 1);
        tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
